// File: rtl/mod_updown_counter.sv
// Up/down counter with a runtime terminal value, wrap or saturate behaviour,
// cascadable terminal count, one-cycle carry pulse and sticky overflow flag.
module mod_updown_counter #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             enable_i,
  input  logic             up_dn_i,
  input  logic [WIDTH-1:0] max_val_i,
  input  logic             sat_mode_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             carry_o,
  output logic             ovf_sticky_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             ovf_q,   ovf_d;
  logic             tc;
  logic             bev;

  // Terminal count: a count loaded above max_val still counts as "at the top"
  // when counting up, so the next enabled step wraps or clamps.
  always_comb begin
    tc = up_dn_i ? (count_q >= max_val_i) : (count_q == '0);
  end

  // Boundary event only when an actual step is attempted at the bound.
  always_comb begin
    bev = enable_i & ~clr_i & ~load_i & tc;
  end

  // Next-state: clr beats load beats enable.
  always_comb begin
    count_d = count_q;
    carry_d = bev;
    ovf_d   = ovf_q;

    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (enable_i) begin
      if (up_dn_i) begin
        if (tc) begin
          if (sat_mode_i) begin
            // Clamp a value that was loaded above the terminal value.
            count_d = (count_q > max_val_i) ? max_val_i : count_q;
          end else begin
            count_d = '0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (tc) begin
          count_d = sat_mode_i ? '0 : max_val_i;
        end else begin
          // Counting down from above max_val is allowed and just decrements.
          count_d = count_q - 1'b1;
        end
      end
    end

    // Set wins over clear when both land on the same edge.
    if (bev) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RESET_VAL;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o      = count_q;
  assign tc_o         = tc;
  assign carry_o      = carry_q;
  assign ovf_sticky_o = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: wrap, saturate, load, priority,
// overflow flag, async reset and a two-stage 4-bit cascade.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, enable, up_dn, sat_mode, ovf_clr;
  logic [7:0] load_val, max_val;
  logic [7:0] count;
  logic       tc, carry, ovf;

  logic       cas_en;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, hi_tc, lo_carry, hi_carry, lo_ovf, hi_ovf;
  logic       hi_en;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .enable_i(enable), .up_dn_i(up_dn), .max_val_i(max_val), .sat_mode_i(sat_mode),
    .ovf_clr_i(ovf_clr), .count_o(count), .tc_o(tc), .carry_o(carry), .ovf_sticky_o(ovf)
  );

  assign hi_en = cas_en & lo_tc;

  mod_updown_counter #(.WIDTH(4), .RESET_VAL(4'd0)) u_lo (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0), .load_i(1'b0), .load_val_i(4'd0),
    .enable_i(cas_en), .up_dn_i(1'b1), .max_val_i(4'd15), .sat_mode_i(1'b0),
    .ovf_clr_i(1'b0), .count_o(lo_count), .tc_o(lo_tc), .carry_o(lo_carry),
    .ovf_sticky_o(lo_ovf)
  );

  mod_updown_counter #(.WIDTH(4), .RESET_VAL(4'd0)) u_hi (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0), .load_i(1'b0), .load_val_i(4'd0),
    .enable_i(hi_en), .up_dn_i(1'b1), .max_val_i(4'd15), .sat_mode_i(1'b0),
    .ovf_clr_i(1'b0), .count_o(hi_count), .tc_o(hi_tc), .carry_o(hi_carry),
    .ovf_sticky_o(hi_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (count !== 8'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL reset_carry got %b want 0", carry); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", ovf); end
    tests_run++;
    if (tc !== 1'b0) begin tests_failed++; $display("FAIL reset_tc got %b want 0", tc); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (count !== 8'd0) begin tests_failed++; $display("FAIL reset_hold got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_cnt;
    logic       exp_car, exp_ovf;
    exp_cnt = 8'd0;
    exp_ovf = 1'b0;
    max_val = 8'd9; up_dn = 1'b1; sat_mode = 1'b0; enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      exp_car = (exp_cnt == 8'd9);
      exp_cnt = (exp_cnt == 8'd9) ? 8'd0 : exp_cnt + 8'd1;
      exp_ovf = exp_ovf | exp_car;
      tests_run++;
      if (count !== exp_cnt) begin tests_failed++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count, exp_cnt); end
      tests_run++;
      if (carry !== exp_car) begin tests_failed++; $display("FAIL wrap_carry[%0d] got %b want %b", i, carry, exp_car); end
      tests_run++;
      if (ovf !== exp_ovf) begin tests_failed++; $display("FAIL wrap_ovf[%0d] got %b want %b", i, ovf, exp_ovf); end
    end
    // Down from 0 in wrap mode goes to max_val.
    enable = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; up_dn = 1'b0; enable = 1'b1;
    #1;
    tests_run++;
    if (tc !== 1'b1) begin tests_failed++; $display("FAIL down_tc_at_zero got %b want 1", tc); end
    tick();
    tests_run++;
    if (count !== 8'd9) begin tests_failed++; $display("FAIL down_wrap_count got %0d want 9", count); end
    tests_run++;
    if (carry !== 1'b1) begin tests_failed++; $display("FAIL down_wrap_carry got %b want 1", carry); end
    tick();
    tests_run++;
    if (count !== 8'd8) begin tests_failed++; $display("FAIL down_step_count got %0d want 8", count); end
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL down_step_carry got %b want 0", carry); end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_cnt;
    logic       exp_car;
    enable = 1'b0; clr = 1'b1; ovf_clr = 1'b1;
    tick();
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL sat_ovf_cleared got %b want 0", ovf); end
    clr = 1'b0; ovf_clr = 1'b0;
    sat_mode = 1'b1; max_val = 8'd5; up_dn = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_cnt = (i < 5) ? 8'(i) : 8'd5;
      exp_car = (i >= 6);
      tests_run++;
      if (count !== exp_cnt) begin tests_failed++; $display("FAIL sat_count[%0d] got %0d want %0d", i, count, exp_cnt); end
      tests_run++;
      if (carry !== exp_car) begin tests_failed++; $display("FAIL sat_carry[%0d] got %b want %b", i, carry, exp_car); end
    end
    clr = 1'b1;
    tick();
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL clr_carry got %b want 0", carry); end
    clr = 1'b0; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (count !== 8'd0) begin tests_failed++; $display("FAIL sat_down_count[%0d] got %0d want 0", i, count); end
      tests_run++;
      if (carry !== 1'b1) begin tests_failed++; $display("FAIL sat_down_carry[%0d] got %b want 1", i, carry); end
    end
  endtask

  task automatic test_load();
    max_val = 8'd100; sat_mode = 1'b1; up_dn = 1'b1; enable = 1'b1;
    load = 1'b1; load_val = 8'd200;
    tick();
    tests_run++;
    if (count !== 8'd200) begin tests_failed++; $display("FAIL load_count got %0d want 200", count); end
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL load_carry got %b want 0", carry); end
    tests_run++;
    if (tc !== 1'b1) begin tests_failed++; $display("FAIL load_tc_above_max got %b want 1", tc); end
    load = 1'b0;
    tick();
    tests_run++;
    if (count !== 8'd100) begin tests_failed++; $display("FAIL load_sat_clamp got %0d want 100", count); end
    tests_run++;
    if (carry !== 1'b1) begin tests_failed++; $display("FAIL load_sat_carry got %b want 1", carry); end
    load = 1'b1;
    tick();
    load = 1'b0; sat_mode = 1'b0;
    tick();
    tests_run++;
    if (count !== 8'd0) begin tests_failed++; $display("FAIL load_wrap_count got %0d want 0", count); end
    tests_run++;
    if (carry !== 1'b1) begin tests_failed++; $display("FAIL load_wrap_carry got %b want 1", carry); end
    load = 1'b1;
    tick();
    load = 1'b0; up_dn = 1'b0;
    tick();
    tests_run++;
    if (count !== 8'd199) begin tests_failed++; $display("FAIL load_down1 got %0d want 199", count); end
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL load_down_carry got %b want 0", carry); end
    tick();
    tests_run++;
    if (count !== 8'd198) begin tests_failed++; $display("FAIL load_down2 got %0d want 198", count); end
  endtask

  task automatic test_priority();
    up_dn = 1'b1; sat_mode = 1'b1; max_val = 8'd100; enable = 1'b1;
    tick();
    tests_run++;
    if (carry !== 1'b1) begin tests_failed++; $display("FAIL prio_setup_carry got %b want 1", carry); end
    clr = 1'b1; load = 1'b1; load_val = 8'd77;
    tick();
    tests_run++;
    if (count !== 8'd0) begin tests_failed++; $display("FAIL prio_clr_count got %0d want 0", count); end
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL prio_clr_carry got %b want 0", carry); end
    clr = 1'b0;
    tick();
    tests_run++;
    if (count !== 8'd77) begin tests_failed++; $display("FAIL prio_load_count got %0d want 77", count); end
    load = 1'b0;
    tick();
    tests_run++;
    if (count !== 8'd78) begin tests_failed++; $display("FAIL prio_step_after_load got %0d want 78", count); end
  endtask

  task automatic test_ovf_clear();
    sat_mode = 1'b0; up_dn = 1'b1; max_val = 8'd3;
    load = 1'b1; load_val = 8'd3;
    tick();
    tests_run++;
    if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_pre got %b want 1", ovf); end
    load = 1'b0; enable = 1'b1; ovf_clr = 1'b1;
    tick();
    tests_run++;
    if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_set_wins got %b want 1", ovf); end
    tests_run++;
    if (count !== 8'd0) begin tests_failed++; $display("FAIL ovf_wrap_count got %0d want 0", count); end
    enable = 1'b0;
    tick();
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", ovf); end
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL ovf_idle_carry got %b want 0", carry); end
    ovf_clr = 1'b0;
    // max_val of zero gives a carry on every enabled edge.
    max_val = 8'd0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (count !== 8'd0) begin tests_failed++; $display("FAIL div1_count[%0d] got %0d want 0", i, count); end
      tests_run++;
      if (carry !== 1'b1) begin tests_failed++; $display("FAIL div1_carry[%0d] got %b want 1", i, carry); end
    end
  endtask

  task automatic test_async_reset();
    sat_mode = 1'b1; max_val = 8'd5; up_dn = 1'b1;
    load = 1'b1; load_val = 8'd5;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    tests_run++;
    if (count !== 8'd5 || carry !== 1'b1 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_setup got count=%0d carry=%b ovf=%b want 5/1/1", count, carry, ovf);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== 8'd0) begin tests_failed++; $display("FAIL areset_count got %0d want 0", count); end
    tests_run++;
    if (carry !== 1'b0) begin tests_failed++; $display("FAIL areset_carry got %b want 0", carry); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL areset_ovf got %b want 0", ovf); end
    enable = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cascade();
    logic [7:0] exp_cnt;
    exp_cnt = 8'd0;
    tests_run++;
    if ({hi_count, lo_count} !== 8'd0) begin tests_failed++; $display("FAIL casc_start got %0d want 0", {hi_count, lo_count}); end
    cas_en = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick();
      exp_cnt = exp_cnt + 8'd1;
      tests_run++;
      if ({hi_count, lo_count} !== exp_cnt) begin
        tests_failed++;
        $display("FAIL casc_count[%0d] got %0d want %0d", i, {hi_count, lo_count}, exp_cnt);
      end
    end
    cas_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; load = 1'b0; enable = 1'b0; up_dn = 1'b1; sat_mode = 1'b0; ovf_clr = 1'b0;
    load_val = 8'd0; max_val = 8'd9; cas_en = 1'b0;
    #12;
    test_reset();
    test_wrap();
    test_saturate();
    test_load();
    test_priority();
    test_ovf_clear();
    test_async_reset();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
